// File: rtl/port_b_uart_tx.sv
// PORTB-driven 8N1 UART transmitter with a small transmit FIFO.
// Frames are sent back-to-back while data is queued; tx is driven from a flop.
module port_b_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               wr_en,
   input  logic [7:0]                         wr_data,
   output logic                               tx,
   output logic                               busy,
   output logic                               fifo_full,
   output logic                               fifo_empty,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
   output logic                               overflow,
   output logic                               tx_done
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int NW = $clog2(FIFO_DEPTH + 1);
   localparam int CW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            tx_done_q, tx_done_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [NW-1:0]   count_q, count_d;
   logic            overflow_q, overflow_d;
   logic [7:0]      mem_q [FIFO_DEPTH];

   logic            full, empty, bit_end, pop, push;

   always_comb begin
      full        = (count_q == NW'(FIFO_DEPTH));
      empty       = (count_q == '0);
      bit_end     = (cnt_q == CW'(CLKS_PER_BIT - 1));
      state_d     = state_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      tx_d        = tx_q;
      tx_done_d   = 1'b0;
      pop         = 1'b0;
      cnt_d       = bit_end ? '0 : cnt_q + CW'(1);

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            tx_d  = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               bit_idx_d = '0;
               tx_d      = shift_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  shift_d   = shift_q >> 1;
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shift_q[1];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               tx_done_d = 1'b1;
               // Chain straight into the next start bit so queued frames have no gap.
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  state_d = START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // A full FIFO still accepts a write when the head leaves on the same edge.
      push       = wr_en && (!full || pop);
      overflow_d = overflow_q | (wr_en & full & ~pop);
      wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d    = count_q;
      if (push && !pop)      count_d = count_q + NW'(1);
      else if (pop && !push) count_d = count_q - NW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         tx_done_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         tx_done_q  <= tx_done_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign tx         = tx_q;
   assign busy       = (state_q != IDLE);
   assign fifo_full  = full;
   assign fifo_empty = empty;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;
   assign tx_done    = tx_done_q;

endmodule
